// File: rtl/core_sched_pkg.sv
// Shared types and helpers for the SHA-256 core scheduler.
package core_sched_pkg;
    localparam int BLK_OP_W = 3;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_START} state_e;

    // Index of the most significant set bit needed to hold v.
    function automatic int msb_of(input int v);
        return (v < 2) ? 0 : $clog2(v + 1) - 1;
    endfunction
endpackage

// File: rtl/core_sched_if.sv
// Thread-side and core-side signal bundle for core_sched.
// master: the scheduler; slave: requesters, data source and cores.
interface core_sched_if #(
    parameter int N_CORES       = 3,
    parameter int N_THREADS     = 2 * N_CORES,
    parameter int N_THREADS_MSB = core_sched_pkg::msb_of(N_THREADS - 1)
);
    import core_sched_pkg::*;

    logic [N_THREADS-1:0]   thread_req;
    logic [BLK_OP_W-1:0]    blk_op;
    logic [31:0]            din;
    logic                   din_valid;
    logic                   din_rd_en;
    logic                   thread_ack;
    logic [N_THREADS_MSB:0] thread_num;
    logic [N_CORES-1:0]     core_ready;
    logic [N_CORES-1:0]     core_wr_en;
    logic [31:0]            core_din;
    logic [3:0]             core_wr_addr;
    logic [BLK_OP_W-1:0]    core_blk_op;
    logic                   core_seq;
    logic [N_CORES-1:0]     core_start;
    logic                   err;

    modport master (
        input  thread_req, blk_op, din, din_valid, core_ready,
        output din_rd_en, thread_ack, thread_num, core_wr_en, core_din,
               core_wr_addr, core_blk_op, core_seq, core_start, err
    );

    modport slave (
        output thread_req, blk_op, din, din_valid, core_ready,
        input  din_rd_en, thread_ack, thread_num, core_wr_en, core_din,
               core_wr_addr, core_blk_op, core_seq, core_start, err
    );
endinterface

// File: rtl/core_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester strictly
// after i_last, wrapping from N-1 to 0.
module rr_arbiter #(
    parameter int N = 6,
    parameter int W = 3
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_last,
    output logic [N-1:0] o_gnt
);
    int w_idx;

    // Scan farthest-first so the nearest requester overwrites the result.
    always_comb begin
        o_gnt = '0;
        w_idx = 0;
        for (int k = N; k >= 1; k--) begin
            w_idx = int'(i_last) + k;
            if (w_idx >= N) w_idx = w_idx - N;
            if (i_req[w_idx]) begin
                o_gnt        = '0;
                o_gnt[w_idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/core_sched.sv
// Streams 16-word blocks from granted threads into SHA-256 cores.
// Optional sticky core-not-ready check: define CORE_SCHED_ERR_EN.
module core_sched
    import core_sched_pkg::*;
#(
    parameter int N_CORES       = 3,
    parameter int N_THREADS     = 2 * N_CORES,
    parameter int N_THREADS_MSB = msb_of(N_THREADS - 1)
) (
    input  logic         CLK,
    input  logic         RST,
    core_sched_if.master bus
);
    localparam int TW = N_THREADS_MSB + 1;

    state_e              r_state, w_next;
    logic [TW-1:0]       r_thread_num, r_last, w_gnt_idx;
    logic [3:0]          r_cnt;
    logic                r_seq;
    logic [BLK_OP_W-1:0] r_blk_op;
    logic [N_THREADS-1:0] w_elig, w_gnt_oh;
    logic [N_CORES-1:0]  w_core_oh;
    logic                w_grant, w_wr;

    for (genvar t = 0; t < N_THREADS; t++) begin : g_elig
        assign w_elig[t] = bus.thread_req[t] & bus.core_ready[t/2];
    end

    for (genvar c = 0; c < N_CORES; c++) begin : g_core
        assign w_core_oh[c] = (int'(r_thread_num >> 1) == c);
    end

    rr_arbiter #(.N(N_THREADS), .W(TW)) u_arb (
        .i_req  (w_elig),
        .i_last (r_last),
        .o_gnt  (w_gnt_oh)
    );

    always_comb begin
        w_gnt_idx = '0;
        for (int t = 0; t < N_THREADS; t++)
            if (w_gnt_oh[t]) w_gnt_idx = TW'(t);
    end

    // Grant is masked during reset so no strobe escapes while RST is high.
    assign w_grant = (r_state == ST_IDLE) & (|w_elig) & ~RST;
    assign w_wr    = (r_state == ST_LOAD) & bus.din_valid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_grant) w_next = ST_LOAD;
            ST_LOAD:  if (w_wr && r_cnt == 4'd15) w_next = ST_START;
            ST_START: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.thread_ack   = w_grant;
        bus.thread_num   = w_grant ? w_gnt_idx : r_thread_num;
        bus.din_rd_en    = w_wr;
        bus.core_wr_en   = w_wr ? w_core_oh : '0;
        bus.core_din     = w_wr ? bus.din : '0;
        bus.core_wr_addr = r_cnt;
        bus.core_blk_op  = r_blk_op;
        bus.core_seq     = r_seq;
        bus.core_start   = (r_state == ST_START) ? w_core_oh : '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_thread_num <= '0;
            r_last       <= TW'(N_THREADS - 1);
            r_cnt        <= '0;
            r_seq        <= 1'b0;
            r_blk_op     <= '0;
        end else if (w_grant) begin
            r_thread_num <= w_gnt_idx;
            r_last       <= w_gnt_idx;
            r_cnt        <= '0;
            r_seq        <= w_gnt_idx[0];
            r_blk_op     <= bus.blk_op;
        end else if (w_wr) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

`ifdef CORE_SCHED_ERR_EN
    logic r_err;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_err <= 1'b0;
        else if (r_state == ST_LOAD && !(|(bus.core_ready & w_core_oh)))
            r_err <= 1'b1;
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_core_sched.sv
// Self-checking bench for core_sched: eligibility table, scoreboarded
// block writes, round-robin order, stalls, reset abort and error flag.
module tb_core_sched;
    import core_sched_pkg::*;

    localparam int NC = 3;
    localparam int NT = 6;
    localparam logic [NC-1:0] RDY_ALL = '1;
`ifdef CORE_SCHED_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_starts = 0;
    bit   sb_en = 1'b1;

    typedef struct packed {
        logic [NC-1:0] mask;
        logic [3:0]    addr;
        logic [31:0]   data;
    } wr_t;
    wr_t sbq[$];

    typedef struct {
        logic [NT-1:0] req;
        logic [NC-1:0] rdy;
        logic          ack;
        int            num;
    } vec_t;
    vec_t vecs[9];

    core_sched_if #(.N_CORES(NC)) bus ();
    core_sched #(.N_CORES(NC)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard: every core write must match the next pushed expectation.
    always @(negedge CLK) begin
        wr_t e;
        if (!RST && sb_en && |bus.core_wr_en) begin
            if (sbq.size() == 0) begin
                chk("unexpected_write", {29'd0, bus.core_wr_en}, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("wr_en", {29'd0, bus.core_wr_en}, {29'd0, e.mask});
                chk("wr_addr", {28'd0, bus.core_wr_addr}, {28'd0, e.addr});
                chk("wr_data", bus.core_din, e.data);
            end
        end
        if (!RST && |bus.core_start) n_starts++;
    end

    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1'b1;
        bus.thread_req = '0;
        bus.din_valid  = 1'b0;
        bus.din        = '0;
        bus.blk_op     = '0;
        bus.core_ready = RDY_ALL;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},    {31'd0, bus.thread_ack}, 32'd0);
        chk({tag, "_rd_en"},  {31'd0, bus.din_rd_en}, 32'd0);
        chk({tag, "_wr_en"},  {29'd0, bus.core_wr_en}, 32'd0);
        chk({tag, "_start"},  {29'd0, bus.core_start}, 32'd0);
        chk({tag, "_num"},    {29'd0, bus.thread_num}, 32'd0);
        chk({tag, "_seq"},    {31'd0, bus.core_seq}, 32'd0);
        chk({tag, "_blk_op"}, {29'd0, bus.core_blk_op}, 32'd0);
        chk({tag, "_addr"},   {28'd0, bus.core_wr_addr}, 32'd0);
        chk({tag, "_din"},    bus.core_din, 32'd0);
        chk({tag, "_err"},    {31'd0, bus.err}, 32'd0);
    endtask

    // Called at posedge+1; returns at posedge+1 of the first LOAD cycle.
    task automatic wait_ack(input int thr, output int ack_cyc);
        bit got = 1'b0;
        ack_cyc = 0;
        bus.thread_req[thr] = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge CLK);
            if (bus.thread_ack) begin
                got = 1'b1;
                ack_cyc = cyc;
                chk("ack_num", {29'd0, bus.thread_num}, thr);
            end
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        @(posedge CLK); #1;
        bus.thread_req[thr] = 1'b0;
        chk("ack_pulse", {31'd0, bus.thread_ack}, 32'd0);
        chk("num_held", {29'd0, bus.thread_num}, thr);
        chk("seq", {31'd0, bus.core_seq}, thr & 1);
        chk("blk_op", {29'd0, bus.core_blk_op}, {29'd0, bus.blk_op});
    endtask

    task automatic feed(input logic [31:0] base, input logic [NC-1:0] mask,
                        input int stall_at, input int stall_len, input int drop_at,
                        input int abort_at, input int ack_cyc, input int exp_delta);
        int w = 0;
        int st = 0;
        logic v;
        for (int i = 0; i < 80 && w < 16; i++) begin
            if (w == abort_at) begin
                RST = 1'b1;
                bus.din_valid = 1'b0;
                #1 chk_all_zero("abort");
                @(posedge CLK); #1;
                RST = 1'b0;
                return;
            end
            v = 1'b1;
            if (w == stall_at && st < stall_len) begin
                v = 1'b0;
                st++;
            end
            bus.din_valid  = v;
            bus.din        = base + 32'(w);
            bus.core_ready = (w == drop_at && v) ? (RDY_ALL & ~mask) : RDY_ALL;
            if (v) sbq.push_back('{mask, 4'(w), base + 32'(w)});
            @(negedge CLK);
            chk("rd_en", {31'd0, bus.din_rd_en}, {31'd0, v});
            if (!v) chk("stall_addr", {28'd0, bus.core_wr_addr}, w);
            @(posedge CLK); #1;
            if (v) w++;
        end
        bus.din_valid  = 1'b0;
        bus.core_ready = RDY_ALL;
        if (w < 16) chk("load_timeout", w, 16);
        @(negedge CLK);
        chk("start", {29'd0, bus.core_start}, {29'd0, mask});
        chk("start_delay", cyc - ack_cyc, exp_delta);
        @(negedge CLK);
        chk("start_pulse", {29'd0, bus.core_start}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int a0, a1, snap, ng;
        int gnum[7];
        int gcyc[7];
        int exp_order[7];

        vecs[0] = '{6'b000001, 3'b111, 1'b1, 0};
        vecs[1] = '{6'b001100, 3'b101, 1'b0, 0};
        vecs[2] = '{6'b001100, 3'b111, 1'b1, 2};
        vecs[3] = '{6'b110000, 3'b011, 1'b0, 0};
        vecs[4] = '{6'b110000, 3'b100, 1'b1, 4};
        vecs[5] = '{6'b000010, 3'b001, 1'b1, 1};
        vecs[6] = '{6'b101010, 3'b111, 1'b1, 1};
        vecs[7] = '{6'b000000, 3'b111, 1'b0, 0};
        vecs[8] = '{6'b100000, 3'b111, 1'b1, 5};
        exp_order = '{0, 1, 2, 3, 4, 5, 0};

        bus.thread_req = '0;
        bus.din_valid  = 1'b0;
        bus.din        = '0;
        bus.blk_op     = '0;
        bus.core_ready = RDY_ALL;

        // Reset state, including no grant while RST is high.
        bus.thread_req = 6'b000001;
        #1 chk("rst_ack_masked", {31'd0, bus.thread_ack}, 32'd0);
        do_reset();
        chk_all_zero("reset");

        // Eligibility and first-grant table; pointer starts at N_THREADS-1.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            bus.thread_req = vecs[i].req;
            bus.core_ready = vecs[i].rdy;
            @(negedge CLK);
            chk($sformatf("vec%0d_ack", i), {31'd0, bus.thread_ack}, {31'd0, vecs[i].ack});
            if (vecs[i].ack) chk($sformatf("vec%0d_num", i), {29'd0, bus.thread_num}, vecs[i].num);
            chk($sformatf("vec%0d_wr", i), {29'd0, bus.core_wr_en}, 32'd0);
        end

        // Basic block on thread 0; blk_op latched at grant.
        do_reset();
        bus.blk_op = 3'b011;
        wait_ack(0, a0);
        bus.blk_op = 3'b000;
        feed(32'hA000_0000, 3'b001, -1, 0, -1, -1, a0, 17);
        chk("blk_op_held", {29'd0, bus.core_blk_op}, 32'd3);

        // Five-cycle din_valid gap after word 7.
        do_reset();
        wait_ack(0, a0);
        feed(32'hB000_0010, 3'b001, 8, 5, -1, -1, a0, 22);

        // Core 1 not ready blocks threads 2/3; then back-to-back 2 and 3.
        do_reset();
        bus.thread_req = 6'b001100;
        bus.core_ready = 3'b101;
        repeat (3) begin
            @(negedge CLK);
            chk("not_ready_ack", {31'd0, bus.thread_ack}, 32'd0);
        end
        @(posedge CLK); #1;
        bus.core_ready = RDY_ALL;
        wait_ack(2, a0);
        feed(32'hC000_0000, 3'b010, -1, 0, -1, -1, a0, 17);
        chk("b2b_ack", {31'd0, bus.thread_ack}, 32'd1);
        chk("b2b_num", {29'd0, bus.thread_num}, 32'd3);
        a1 = cyc;
        chk("b2b_interval", a1 - a0, 18);
        @(posedge CLK); #1;
        bus.thread_req[3] = 1'b0;
        chk("b2b_seq", {31'd0, bus.core_seq}, 32'd1);
        feed(32'hC100_0000, 3'b010, -1, 0, -1, -1, a1, 17);

        // All threads held: strict round-robin every 18 cycles.
        do_reset();
        sb_en = 1'b0;
        bus.thread_req = '1;
        bus.din_valid  = 1'b1;
        ng = 0;
        for (int i = 0; i < 200 && ng < 7; i++) begin
            @(negedge CLK);
            if (bus.thread_ack) begin
                gnum[ng] = int'(bus.thread_num);
                gcyc[ng] = cyc;
                ng++;
            end
        end
        chk("rr_count", ng, 7);
        for (int i = 0; i < ng; i++) begin
            chk($sformatf("rr_order%0d", i), gnum[i], exp_order[i]);
            if (i > 0) chk($sformatf("rr_gap%0d", i), gcyc[i] - gcyc[i-1], 18);
        end
        do_reset();
        sb_en = 1'b1;

        // Reset at word 10: no start, restart from thread 0 at addr 0.
        do_reset();
        bus.blk_op = 3'b111;
        wait_ack(0, a0);
        snap = n_starts;
        feed(32'hD000_0000, 3'b001, -1, 0, -1, 10, a0, 17);
        bus.blk_op = 3'b000;
        repeat (20) @(posedge CLK);
        #1 chk("abort_no_start", n_starts, snap);
        bus.thread_req = 6'b100001;
        wait_ack(0, a0);
        bus.thread_req[5] = 1'b0;
        feed(32'hD100_0000, 3'b001, -1, 0, -1, -1, a0, 17);

        // core_ready drop at word 3 of a core-1 block.
        do_reset();
        wait_ack(2, a0);
        feed(32'hE000_0000, 3'b010, -1, 0, 3, -1, a0, 17);
        chk("err_after_block", {31'd0, bus.err}, {31'd0, ERR_EXP});
        repeat (5) @(posedge CLK);
        #1 chk("err_sticky", {31'd0, bus.err}, {31'd0, ERR_EXP});
        do_reset();
        chk("err_cleared", {31'd0, bus.err}, 32'd0);

        chk("sb_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/core_sched.md
CORE_SCHED -- requirements
Module: core_sched

Interface
REQ-001: Parameter N_CORES, default 3: number of SHA-256 cores served.
REQ-002: Parameter N_THREADS, default 2*N_CORES: thread slots; thread t maps to core t>>1 with seq t&1.
REQ-003: Parameter N_THREADS_MSB, default `MSB(N_THREADS-1): thread number width minus 1.
REQ-004: CLK  in  1  sole clock; all logic rising-edge.
REQ-005: RST  in  1  asynchronous, active-high reset.
REQ-006: thread_req  in  N_THREADS  thread has one 16-word block ready.
REQ-007: blk_op  in  `BLK_OP_MSB+1  block operation; sampled at grant.
REQ-008: din  in  32  block data word.
REQ-009: din_valid  in  1  din holds a valid word.
REQ-010: din_rd_en  out  1  word consumed this cycle.
REQ-011: thread_ack  out  1  one-cycle grant pulse.
REQ-012: thread_num  out  N_THREADS_MSB+1  granted thread; held from grant until return to IDLE.
REQ-013: core_ready  in  N_CORES  core can accept a block.
REQ-014: core_wr_en  out  N_CORES  one-hot word write strobe.
REQ-015: core_din  out  32  word to core.
REQ-016: core_wr_addr  out  4  word index 0..15.
REQ-017: core_blk_op  out  `BLK_OP_MSB+1  latched blk_op.
REQ-018: core_seq  out  1  latched thread seq bit.
REQ-019: core_start  out  N_CORES  one-hot one-cycle start pulse.
REQ-020: err  out  1  sticky error (see Configuration).

Function
REQ-021: FSM states IDLE, LOAD, START; IDLE -> LOAD on grant, LOAD -> START after word 15 written, START -> IDLE unconditionally.
REQ-022: Thread t is eligible in IDLE iff thread_req[t] & core_ready[t>>1].
REQ-023: Grant is round-robin: first eligible thread strictly after the last granted thread, wrapping at N_THREADS-1 to 0.
REQ-024: On grant: thread_ack=1 for exactly one cycle, thread_num, core_seq, core_blk_op latched, word counter cleared.
REQ-025: In LOAD: din_rd_en = din_valid; when din_valid=1, core_wr_en[core]=1, core_din=din, core_wr_addr=counter, counter increments.
REQ-026: din_valid=0 in LOAD stalls with no write and no counter change; no timeout.
REQ-027: Word 15 write moves to START next cycle; START asserts core_start[core] for exactly one cycle.
REQ-028: Minimum grant-to-grant interval for back-to-back blocks is 18 cycles (1 IDLE + 16 LOAD + 1 START).
REQ-029: No grant while in LOAD or START; thread_req changes there are ignored.
REQ-030: Requester holds thread_req until thread_ack; requester deasserts it the cycle after ack.
REQ-031: core_wr_en, core_start, din_rd_en, thread_ack are 0 whenever not specified above.

Reset
REQ-032: RST asserted at any time, including mid-LOAD, forces IDLE, counter 0, all strobes 0, thread_num 0, core_seq 0, core_blk_op 0, err 0.
REQ-033: After reset the round-robin pointer is N_THREADS-1 so thread 0 wins first.
REQ-034: A block aborted by reset is not resumed; its core is not started.

Configuration
REQ-035: Macro CORE_SCHED_ERR_EN defined: err sets sticky when core_ready of the granted core is 0 in any LOAD cycle, cleared only by RST.
REQ-036: CORE_SCHED_ERR_EN undefined: err tied 0, no check logic.

Structure
REQ-037: `BLK_OP_MSB and `MSB come from the shared sha256.vh; no new shared constants.
REQ-038: One sub-module rr_arbiter (N-bit request, last-grant pointer, one-hot grant) is natural; FSM and counter stay in core_sched.

Verification
REQ-039: Reset; thread_req=6'b000001, core_ready=3'b111, din_valid=1 words 0..15 -> ack cycle 1, core_wr_en=3'b001 addr 0..15, core_start=3'b001 on cycle 18.
REQ-040: thread_req=6'b111111 held, all ready -> grant order 0,1,2,3,4,5,0.
REQ-041: thread_req=6'b001100, core_ready=3'b101 -> no grant; set core_ready[1] -> thread 2 granted, core_seq=0, core_wr_en=3'b010.
REQ-042: din_valid low for 5 cycles after word 7 -> no writes, addr stays 8, core_start 5 cycles later than REQ-039.
REQ-043: RST pulse at word 10 -> all outputs 0 immediately, no core_start, next grant thread 0 with addr restarting at 0.
REQ-044: CORE_SCHED_ERR_EN defined, core_ready drops at word 3 -> err=1 and stays 1 through block completion until RST.
